// File: rtl/amo_ctrl.sv
// amo_ctrl: LR/SC/AMO sequencer with a reservation set, driving one memory port and an external AMO ALU.
// amo_t encoding: bit5=0, bit4 = D (1) / W (0), bits[3:0]: 1 LR, 2 SC, 3 SWAP, 4 ADD, 5 XOR,
// 6 AND, 7 OR, 8 MIN, 9 MAX, A MINU, B MAXU; every other code is unrecognised.
// Optional AMO_RESV_TIMEOUT_EN: reservation expires RESV_TIMEOUT cycles after the LR that set it.
module amo_ctrl #(
    parameter int RESV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_amo,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_rs2,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_misalign,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_strobe,
    output logic [63:0] mem_wdata,
    input  logic        mem_ok,
    input  logic [63:0] mem_rdata,
    output logic [63:0] alu_m_rs1,
    output logic [63:0] alu_rs2,
    output logic [5:0]  alu_type,
    input  logic [63:0] alu_result,
    input  logic        snoop_valid,
    input  logic [63:0] snoop_addr
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;

    state_t      state_q, state_d;
    logic [5:0]  amo_q, amo_d;
    logic [63:2] addr_q, addr_d;
    logic [63:0] rs2_q, rs2_d;
    logic [63:0] old_q, old_d;
    logic [63:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        resv_valid_q, resv_valid_d;
    logic [63:3] resv_addr_q, resv_addr_d;
    logic        resv_d_q, resv_d_d;
`ifdef AMO_RESV_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
`endif

    logic        accept, req_d, req_known, req_lr, req_sc, req_mis, sc_ok;
    logic        d_q, lr_q, sc_q;
    logic [31:0] load_w;
    logic [63:0] load_val, store_val;
    logic        unused;

    assign accept    = req_valid && req_ready;
    assign req_d     = req_amo[4];
    assign req_known = !req_amo[5] && req_amo[3:0] >= 4'h1 && req_amo[3:0] <= 4'hB;
    assign req_lr    = req_amo[3:0] == 4'h1;
    assign req_sc    = req_amo[3:0] == 4'h2;
    assign req_mis   = req_known && (req_d ? |req_addr[2:0] : |req_addr[1:0]);
    assign sc_ok     = resv_valid_q && resv_addr_q == req_addr[63:3] && resv_d_q == req_d;
    assign d_q       = amo_q[4];
    assign lr_q      = amo_q[3:0] == 4'h1;
    assign sc_q      = amo_q[3:0] == 4'h2;
    assign load_w    = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
    assign load_val  = d_q ? mem_rdata : {{32{load_w[31]}}, load_w};
    assign store_val = sc_q ? rs2_q : alu_result;
    assign alu_m_rs1 = old_q;
    assign alu_rs2   = rs2_q;
    assign alu_type  = amo_q;
`ifdef AMO_RESV_TIMEOUT_EN
    assign unused    = ^snoop_addr[2:0];
`else
    assign unused    = ^{snoop_addr[2:0], 32'(RESV_TIMEOUT)};
`endif

    // State register and datapath flops; reset drops any in-flight access at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            amo_q        <= '0;
            addr_q       <= '0;
            rs2_q        <= '0;
            old_q        <= '0;
            rdata_q      <= '0;
            misalign_q   <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            resv_d_q     <= 1'b0;
`ifdef AMO_RESV_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            amo_q        <= amo_d;
            addr_q       <= addr_d;
            rs2_q        <= rs2_d;
            old_q        <= old_d;
            rdata_q      <= rdata_d;
            misalign_q   <= misalign_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            resv_d_q     <= resv_d_d;
`ifdef AMO_RESV_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Next state: faults, unknown ops and failed SCs respond immediately without touching memory.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = !accept ? IDLE :
                             (req_mis || !req_known) ? RESP :
                             req_sc ? (sc_ok ? STORE : RESP) : LOAD;
            LOAD:  state_d = !mem_ok ? LOAD : lr_q ? RESP : STORE;
            STORE: state_d = mem_ok ? RESP : STORE;
            RESP:  state_d = IDLE;
        endcase
    end

    // Request latch, loaded value and response value capture.
    always_comb begin
        amo_d      = accept ? req_amo : amo_q;
        addr_d     = accept ? req_addr[63:2] : addr_q;
        rs2_d      = accept ? req_rs2 : rs2_q;
        misalign_d = accept ? req_mis : misalign_q;
        old_d      = (state_q == LOAD && mem_ok) ? load_val : old_q;
        rdata_d    = accept ? {63'd0, req_known && !req_mis && req_sc && !sc_ok} :
                     (state_q == LOAD && mem_ok) ? load_val : rdata_q;
    end

    // Reservation: cleared by expiry, any SC or a matching snoop; an LR completing this cycle wins.
    always_comb begin
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        resv_d_d     = resv_d_q;
`ifdef AMO_RESV_TIMEOUT_EN
        cnt_d        = cnt_q;
        if (resv_valid_q) begin
            if (cnt_q == 32'd0)
                resv_valid_d = 1'b0;
            else
                cnt_d = cnt_q - 32'd1;
        end
`endif
        if (accept && req_known && req_sc)
            resv_valid_d = 1'b0;
        if (snoop_valid && snoop_addr[63:3] == resv_addr_q)
            resv_valid_d = 1'b0;
        if (state_q == LOAD && mem_ok && lr_q) begin
            resv_valid_d = 1'b1;
            resv_addr_d  = addr_q[63:3];
            resv_d_d     = d_q;
`ifdef AMO_RESV_TIMEOUT_EN
            cnt_d        = 32'(RESV_TIMEOUT);
`endif
        end
    end

    // Outputs; memory fields are zero whenever no access is pending.
    always_comb begin
        req_ready     = resetn && state_q == IDLE;
        resp_valid    = state_q == RESP;
        resp_data     = resp_valid ? rdata_q : '0;
        resp_misalign = resp_valid && misalign_q;
        mem_valid     = state_q == LOAD || state_q == STORE;
        mem_write     = state_q == STORE;
        mem_addr      = mem_valid ? {addr_q[63:3], 3'b000} : '0;
        mem_strobe    = !mem_write ? 8'h00 : d_q ? 8'hFF : addr_q[2] ? 8'hF0 : 8'h0F;
        mem_wdata     = !mem_write ? '0 : d_q ? store_val : {store_val[31:0], store_val[31:0]};
    end
endmodule
